// File: rtl/regfile_sb.sv
// regfile_sb: architectural register file with per-register pending
// scoreboard and the PC register.
//
// After reset an internal sequencer walks every index and writes zero,
// so the storage array carries no reset and can map onto RAM. While the
// sweep runs, all writeback, allocate and PC-update requests are
// dropped. Reads return zero with busy clear.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   rd_addr / rd_data   NUM_RD packed combinational read ports
//   rd_busy             per-port pending flag of the addressed register
//   wr_en/addr/data     writeback; also retires the pending bit
//   alloc_en/addr       issue marks a destination pending
//   pc_we / pc_in / pc  program counter update and current value
//   init_done           high once the clear sweep has completed
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_INIT | clear sweep: reg[cnt] <= 0 each cycle, requests ignored
// S_RUN  | normal operation: reads, writeback, scoreboard, PC
module regfile_sb #(
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_RD     = 2,
  parameter int                    BYPASS     = 1,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 'h8000_0000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic                         wr_en,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic                         alloc_en,
  input  logic [ADDR_WIDTH-1:0]        alloc_addr,
  input  logic                         pc_we,
  input  logic [DATA_WIDTH-1:0]        pc_in,
  output logic [DATA_WIDTH-1:0]        pc,
  output logic                         init_done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DEPTH-1:0]        pend_q, pend_d;
  logic [DATA_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    run;
  logic                    wr_ok;
  logic                    alloc_ok;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: leave INIT on the edge that clears the last index
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (&cnt_q) state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  // Output logic
  always_comb begin
    run       = (state_q == S_RUN);
    init_done = run;
    wr_ok     = run && wr_en && (wr_addr != '0);
    alloc_ok  = run && alloc_en && (alloc_addr != '0);
  end

  // Clear-sweep counter
  always_comb begin
    cnt_d = cnt_q;
    if (!run) cnt_d = cnt_q + ADDR_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Storage array. It has no reset, and exactly one write port is shared
  // by the sweep and by writeback. A reset cycle writes nothing, so an
  // interrupted sweep simply starts again from index 0.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (!rst) begin
      if (!run) begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
      end else begin
        mem_we    = wr_ok;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Scoreboard. The set is applied after the clear, so when a new
  // producer is allocated to the register being retired in the same
  // cycle, the register stays pending.
  always_comb begin
    pend_d = pend_q;
    if (wr_ok)    pend_d[wr_addr]    = 1'b0;
    if (alloc_ok) pend_d[alloc_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Program counter
  always_comb begin
    pc_d = pc_q;
    if (run && pc_we) pc_d = pc_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

  // Read ports. Index 0 is hard-wired to zero. With bypass enabled, a
  // same-cycle writeback to the addressed register is forwarded, and
  // that register is reported not busy because its producer is retiring.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic                  hit;
    logic [DATA_WIDTH-1:0] data;
    logic                  busy;

    assign addr = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign hit  = (BYPASS != 0) && run && wr_en && (wr_addr == addr);

    always_comb begin
      data = '0;
      busy = 1'b0;
      if (run && (addr != '0)) begin
        if (hit) begin
          data = wr_data;
        end else begin
          data = mem_q[addr];
          busy = pend_q[addr];
        end
      end
    end

    assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = data;
    assign rd_busy[k]                          = busy;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb. It instantiates three configurations:
//   dut 0: default, bypass on
//   dut 1: bypass off
//   dut 2: 16 regs, 3 read ports, 64-bit data
// All three receive the same stimulus. Each cycle the stimulus process
// predicts the outputs from an array-level model of every configuration
// and queues the predictions. A monitor compares the queued predictions
// at the falling edge.
module tb_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wr_en, alloc_en, pc_we;

  logic [9:0]   rd_addr_a, rd_addr_b;
  logic [63:0]  rd_data_a, rd_data_b;
  logic [1:0]   rd_busy_a, rd_busy_b;
  logic [4:0]   wr_addr_a, alloc_addr_a;
  logic [31:0]  wr_data_a, pc_in_a, pc_a, pc_b;
  logic         init_done_a, init_done_b;

  logic [11:0]  rd_addr_c;
  logic [191:0] rd_data_c;
  logic [2:0]   rd_busy_c;
  logic [3:0]   wr_addr_c, alloc_addr_c;
  logic [63:0]  wr_data_c, pc_in_c, pc_c;
  logic         init_done_c;

  regfile_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(2), .BYPASS(1)) u_a (
    .clk(clk), .rst(rst), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .rd_busy(rd_busy_a),
    .wr_en(wr_en), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr_a),
    .pc_we(pc_we), .pc_in(pc_in_a), .pc(pc_a), .init_done(init_done_a));

  regfile_sb #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .NUM_RD(2), .BYPASS(0)) u_b (
    .clk(clk), .rst(rst), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr_en(wr_en), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr_a),
    .pc_we(pc_we), .pc_in(pc_in_a), .pc(pc_b), .init_done(init_done_b));

  regfile_sb #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .NUM_RD(3), .BYPASS(1)) u_c (
    .clk(clk), .rst(rst), .rd_addr(rd_addr_c), .rd_data(rd_data_c), .rd_busy(rd_busy_c),
    .wr_en(wr_en), .wr_addr(wr_addr_c), .wr_data(wr_data_c),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr_c),
    .pc_we(pc_we), .pc_in(pc_in_c), .pc(pc_c), .init_done(init_done_c));

  typedef struct packed {
    logic            rst, wr_en, alloc_en, pc_we;
    logic [4:0]      wa, aa;
    logic [63:0]     wd, pcin;
    logic [2:0][4:0] ra;
  } op_t;

  typedef struct packed {
    logic [1:0]       dut;
    logic [2:0][63:0] data;
    logic [2:0]       busy;
    logic [63:0]      pc;
    logic             init;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: per configuration, register contents, pending
  // bits, PC, and the number of clear-sweep cycles still to run.
  logic [63:0] m_mem  [3][32];
  logic        m_pend [3][32];
  logic [63:0] m_pc   [3];
  int          m_left [3];

  function automatic int depth_of(int d);
    return (d == 2) ? 16 : 32;
  endfunction

  function automatic logic [63:0] mask_of(int d);
    return (d == 2) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic int nrd_of(int d);
    return (d == 2) ? 3 : 2;
  endfunction

  function automatic op_t idle();
    op_t o = '0;
    return o;
  endfunction

  task automatic check(input string name, input int d, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d @%0t: got %h expected %h", name, d, $time, act, exp);
    end
  endtask

  task automatic drive(input op_t o);
    rst          = o.rst;
    wr_en        = o.wr_en;
    alloc_en     = o.alloc_en;
    pc_we        = o.pc_we;
    wr_addr_a    = o.wa;
    alloc_addr_a = o.aa;
    wr_data_a    = o.wd[31:0];
    pc_in_a      = o.pcin[31:0];
    rd_addr_a    = {o.ra[1], o.ra[0]};
    rd_addr_b    = {o.ra[1], o.ra[0]};
    wr_addr_c    = o.wa[3:0];
    alloc_addr_c = o.aa[3:0];
    wr_data_c    = o.wd;
    pc_in_c      = o.pcin;
    rd_addr_c    = {o.ra[2][3:0], o.ra[1][3:0], o.ra[0][3:0]};
  endtask

  function automatic exp_t predict(input op_t o, input int d);
    exp_t       e;
    logic [4:0] a, wa, m;
    e      = '0;
    e.dut  = 2'(d);
    e.init = (m_left[d] == 0);
    e.pc   = m_pc[d];
    m      = 5'(depth_of(d) - 1);
    wa     = o.wa & m;
    for (int k = 0; k < nrd_of(d); k++) begin
      a = o.ra[k] & m;
      if (m_left[d] == 0 && a != 0) begin
        if (d != 1 && o.wr_en && wa == a) begin
          e.data[k] = o.wd & mask_of(d);
        end else begin
          e.data[k] = m_mem[d][a];
          e.busy[k] = m_pend[d][a];
        end
      end
    end
    return e;
  endfunction

  task automatic apply(input op_t o);
    logic [4:0] m, wa, aa;
    for (int d = 0; d < 3; d++) begin
      m  = 5'(depth_of(d) - 1);
      wa = o.wa & m;
      aa = o.aa & m;
      if (o.rst) begin
        m_left[d] = depth_of(d);
        m_pc[d]   = 64'h8000_0000;
        for (int i = 0; i < 32; i++) begin
          m_mem[d][i]  = '0;
          m_pend[d][i] = 1'b0;
        end
      end else if (m_left[d] > 0) begin
        m_left[d]--;
      end else begin
        if (o.wr_en && wa != 0) begin
          m_mem[d][wa]  = o.wd & mask_of(d);
          m_pend[d][wa] = 1'b0;
        end
        if (o.alloc_en && aa != 0) m_pend[d][aa] = 1'b1;
        if (o.pc_we) m_pc[d] = o.pcin & mask_of(d);
      end
    end
  endtask

  // One cycle: drive, queue the predicted outputs, advance the model
  // across the rising edge.
  task automatic step(input op_t o, input bit chk);
    drive(o);
    if (chk) for (int d = 0; d < 3; d++) q.push_back(predict(o, d));
    @(posedge clk);
    apply(o);
    #1;
  endtask

  function automatic op_t rand_op();
    op_t o;
    o.rst      = ($urandom_range(0, 399) == 0);
    o.wr_en    = 1'($urandom_range(0, 1));
    o.wa       = 5'($urandom);
    o.wd       = {$urandom, $urandom};
    o.alloc_en = ($urandom_range(0, 9) < 4);
    o.aa       = ($urandom_range(0, 3) == 0) ? o.wa : 5'($urandom);
    o.pc_we    = ($urandom_range(0, 4) == 0);
    o.pcin     = {$urandom, $urandom};
    for (int k = 0; k < 3; k++)
      o.ra[k] = ($urandom_range(0, 2) == 0) ? o.wa : 5'($urandom);
    return o;
  endfunction

  // Monitor: compare every queued prediction against its DUT.
  exp_t             me;
  logic [2:0][63:0] act_d;
  logic [2:0]       act_b;
  logic [63:0]      act_pc;
  logic             act_i;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      me     = q.pop_front();
      act_d  = '0;
      case (me.dut)
        2'd0: begin
          for (int k = 0; k < 2; k++) act_d[k] = {32'h0, rd_data_a[k*32 +: 32]};
          act_b = {1'b0, rd_busy_a}; act_pc = {32'h0, pc_a}; act_i = init_done_a;
        end
        2'd1: begin
          for (int k = 0; k < 2; k++) act_d[k] = {32'h0, rd_data_b[k*32 +: 32]};
          act_b = {1'b0, rd_busy_b}; act_pc = {32'h0, pc_b}; act_i = init_done_b;
        end
        default: begin
          for (int k = 0; k < 3; k++) act_d[k] = rd_data_c[k*64 +: 64];
          act_b = rd_busy_c; act_pc = pc_c; act_i = init_done_c;
        end
      endcase
      for (int k = 0; k < nrd_of(int'(me.dut)); k++)
        check($sformatf("rd_data%0d", k), int'(me.dut), act_d[k], me.data[k]);
      check("rd_busy", int'(me.dut), {61'h0, act_b}, {61'h0, me.busy});
      check("pc", int'(me.dut), act_pc, me.pc);
      check("init_done", int'(me.dut), {63'h0, act_i}, {63'h0, me.init});
    end
  end

  initial begin
    op_t o;

    // Reset held for two cycles; the first cycle is before any defined state
    o = idle(); o.rst = 1'b1;
    step(o, 1'b0);
    step(o, 1'b1);

    // Clear sweep: writeback, alloc and PC requests made while every
    // configuration is still sweeping must all be dropped
    for (int i = 0; i < 32; i++) begin
      o = idle();
      if (i < 16) begin
        o.wr_en = 1'b1; o.wa = 5'd5; o.wd = 64'hDEAD;
        o.alloc_en = 1'b1; o.aa = 5'd5;
        o.pc_we = 1'b1; o.pcin = 64'h1234;
      end
      o.ra[0] = 5'd5; o.ra[1] = 5'(i); o.ra[2] = 5'(31 - i);
      step(o, 1'b1);
    end

    // Every register reads zero after the sweep
    for (int i = 0; i < 32; i++) begin
      o = idle(); o.ra[0] = 5'(i); o.ra[1] = 5'(31 - i); o.ra[2] = 5'(i ^ 7);
      step(o, 1'b1);
    end

    // Write, then a discarded write to x0, then a PC update
    o = idle(); o.wr_en = 1'b1; o.wa = 5'd3; o.wd = 64'h1234_5678; step(o, 1'b1);
    o = idle(); o.wr_en = 1'b1; o.wa = 5'd0; o.wd = 64'hFFFF_FFFF_FFFF_FFFF;
    o.ra[0] = 5'd3; o.ra[1] = 5'd0; step(o, 1'b1);
    o = idle(); o.pc_we = 1'b1; o.pcin = 64'h8000_0004; o.ra[0] = 5'd3; step(o, 1'b1);
    o = idle(); o.ra[1] = 5'd0; step(o, 1'b1);

    // Same-cycle forwarding, then the value the write leaves behind
    o = idle(); o.wr_en = 1'b1; o.wa = 5'd7; o.wd = 64'hCAFE_BABE;
    o.ra[1] = 5'd7; o.ra[2] = 5'd7; step(o, 1'b1);
    o = idle(); o.ra[1] = 5'd7; o.ra[2] = 5'd7; step(o, 1'b1);

    // Scoreboard: alloc, retire, alloc together with retire, alloc of x0
    o = idle(); o.alloc_en = 1'b1; o.aa = 5'd10; o.ra[0] = 5'd10; step(o, 1'b1);
    o = idle(); o.ra[0] = 5'd10; step(o, 1'b1);
    o = idle(); o.wr_en = 1'b1; o.wa = 5'd10; o.wd = 64'd5; o.ra[0] = 5'd10; step(o, 1'b1);
    o = idle(); o.ra[0] = 5'd10; step(o, 1'b1);
    o = idle(); o.wr_en = 1'b1; o.wa = 5'd10; o.wd = 64'd6;
    o.alloc_en = 1'b1; o.aa = 5'd10; o.ra[0] = 5'd10; step(o, 1'b1);
    o = idle(); o.ra[0] = 5'd10; step(o, 1'b1);
    o = idle(); o.alloc_en = 1'b1; o.aa = 5'd0; o.ra[0] = 5'd0; step(o, 1'b1);
    o = idle(); o.ra[0] = 5'd0; o.ra[1] = 5'd10; step(o, 1'b1);

    // Reset in RUN with x3 = 1 and x10 pending, and again at sweep count 17
    o = idle(); o.wr_en = 1'b1; o.wa = 5'd3; o.wd = 64'h1;
    o.alloc_en = 1'b1; o.aa = 5'd10; step(o, 1'b1);
    o = idle(); o.ra[0] = 5'd3; o.ra[1] = 5'd10; step(o, 1'b1);
    o = idle(); o.rst = 1'b1; step(o, 1'b1);
    for (int i = 0; i < 17; i++) begin
      o = idle(); o.ra[0] = 5'd3; step(o, 1'b1);
    end
    o = idle(); o.rst = 1'b1; step(o, 1'b1);
    for (int i = 0; i < 34; i++) begin
      o = idle(); o.ra[0] = 5'd3; o.ra[1] = 5'd10; o.ra[2] = 5'd10;
      step(o, 1'b1);
    end

    // Wide data round trip
    o = idle(); o.wr_en = 1'b1; o.wa = 5'd9; o.wd = 64'h0123_4567_89AB_CDEF; step(o, 1'b1);
    o = idle(); o.ra[0] = 5'd9; o.ra[1] = 5'd3; o.ra[2] = 5'd9; step(o, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) step(rand_op(), 1'b1);

    o = idle(); step(o, 1'b1);
    @(negedge clk);
    #1;
    check("queue_drained", 0, 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
